// File: rtl/mips_pkg.sv
// ============================================================================
//  Package   : mips_pkg
//  Purpose   : Shared register-file defaults, register address type, r0 index.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;
    localparam int AW_DEF     = $clog2(DEPTH_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
//  Module    : regfile_scoreboard
//  Purpose   : Per-register pending flags and a registered count of them.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             resv_en,
    input  logic [AW-1:0]    resv_addr,
    output logic [DEPTH-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    logic [DEPTH-1:0] r_busy;
    logic [AW:0]      r_cnt;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;

    // Release is applied before reserve so a same-cycle new producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wr_en && (wr_addr != AW'(REG_ZERO))) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (resv_en && (resv_addr != AW'(REG_ZERO))) begin
            w_busy_nxt[resv_addr] = 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign busy     = r_busy;
    assign busy_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/mips_regfile.sv
// ============================================================================
//  Module    : mips_regfile
//  Purpose   : Multi-read-port register file, r0 hardwired to zero, with a
//              pending scoreboard. Define REGFILE_BYPASS_EN for write-through.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_RD   = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     resv_en,
    input  logic [AW-1:0]            resv_addr,
    output logic [AW:0]              busy_cnt
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  w_busy;
    logic              w_wr_hit;

    assign w_wr_hit = wr_en && (wr_addr != AW'(REG_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .resv_en   (resv_en),
        .resv_addr (resv_addr),
        .busy      (w_busy),
        .busy_cnt  (busy_cnt)
    );

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0]     w_addr;
        logic [DATA_W-1:0] w_stored;

        assign w_addr   = rd_addr[g*AW +: AW];
        assign w_stored = (w_addr == AW'(REG_ZERO)) ? '0 : r_mem[w_addr];

`ifdef REGFILE_BYPASS_EN
        logic w_fwd;
        assign w_fwd = w_wr_hit && (wr_addr == w_addr);
        // A forwarded value is still pending if a new producer claims it now.
        assign rd_data[g*DATA_W +: DATA_W] = w_fwd ? wr_data : w_stored;
        assign rd_busy[g] = w_fwd ? (resv_en && (resv_addr == wr_addr))
                                  : w_busy[w_addr];
`else
        assign rd_data[g*DATA_W +: DATA_W] = w_stored;
        assign rd_busy[g]                  = w_busy[w_addr];
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_regfile.sv
// ============================================================================
//  Module    : tb_mips_regfile
//  Purpose   : Scoreboard bench for mips_regfile (3 ports, 64-bit, 16 regs).
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_regfile;

    localparam int DW  = 64;
    localparam int DP  = 16;
    localparam int NR  = 3;
    localparam int AWT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR*AWT-1:0] rd_addr = '0;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wr_en = 1'b0;
    logic [AWT-1:0]    wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              resv_en = 1'b0;
    logic [AWT-1:0]    resv_addr = '0;
    logic [AWT:0]      busy_cnt;

    mips_regfile #(
        .DATA_W (DW),
        .DEPTH  (DP),
        .NUM_RD (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .resv_en   (resv_en),
        .resv_addr (resv_addr),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0][DW-1:0] d;
        logic [NR-1:0]         b;
        logic [AWT:0]          cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [DW-1:0] m_mem  [DP];
    bit            m_busy [DP];
    int            n_cmp  = 0;
    int            n_bad  = 0;

    task automatic model_clear();
        for (int i = 0; i < DP; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // One cycle: drive inputs, predict this cycle's outputs, then take the edge.
    task automatic step(input bit we, input int wa, input logic [DW-1:0] wd,
                        input bit re, input int ra,
                        input int a0, input int a1, input int a2, input bit rs);
        exp_t e;
        int   a [NR];
        int   cnt;
        a[0] = a0; a[1] = a1; a[2] = a2;
        rst = rs;
        if (rs) model_clear();
        wr_en = we; wr_addr = AWT'(wa); wr_data = wd;
        resv_en = re; resv_addr = AWT'(ra);
        for (int p = 0; p < NR; p++) rd_addr[p*AWT +: AWT] = AWT'(a[p]);
        cnt = 0;
        for (int i = 0; i < DP; i++) cnt += m_busy[i] ? 1 : 0;
        e.cnt = (AWT+1)'(cnt);
        for (int p = 0; p < NR; p++) begin
            e.d[p] = (a[p] == 0) ? '0 : m_mem[a[p]];
            e.b[p] = m_busy[a[p]];
`ifdef REGFILE_BYPASS_EN
            if (!rs && we && wa != 0 && wa == a[p]) begin
                e.d[p] = wd;
                e.b[p] = re && (ra == wa);
            end
`endif
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (!rs) begin
            if (we && wa != 0) begin
                m_mem[wa]  = wd;
                m_busy[wa] = 1'b0;
            end
            if (re && ra != 0) m_busy[ra] = 1'b1;
        end
        #1;
    endtask

    task automatic rd3(input int a0, input int a1, input int a2);
        step(0, 0, '0, 0, 0, a0, a1, a2, 0);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < NR; p++) begin
                    n_cmp++;
                    if (rd_data[p*DW +: DW] !== e.d[p]) begin
                        n_bad++;
                        $display("FAIL rd_data port%0d @%0t: got %h expected %h",
                                 p, $time, rd_data[p*DW +: DW], e.d[p]);
                    end
                    n_cmp++;
                    if (rd_busy[p] !== e.b[p]) begin
                        n_bad++;
                        $display("FAIL rd_busy port%0d @%0t: got %b expected %b",
                                 p, $time, rd_busy[p], e.b[p]);
                    end
                end
                n_cmp++;
                if (busy_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL busy_cnt @%0t: got %0d expected %0d",
                             $time, busy_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        model_clear();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, then reset mid-run after writing r5 and reserving r2.
        rd3(0, 5, 15);
        step(1, 5, 64'hDEADBEEF, 1, 2, 5, 2, 0, 0);
        rd3(5, 2, 1);
        step(1, 6, 64'h1111, 0, 0, 5, 2, 6, 1);   // reset during a write
        for (int i = 0; i < DP; i += 3) step(0, 0, '0, 0, 0, i, (i+1)%DP, (i+2)%DP, 1);
        rd3(5, 6, 2);

        // Writes to r0 are ignored.
        step(1, 0, 64'h1234, 0, 0, 0, 0, 0, 0);
        rd3(0, 0, 0);

        // Same-cycle read of a write from all ports.
        step(1, 7, 64'hA5A5A5A5, 0, 0, 7, 7, 7, 0);
        rd3(7, 7, 7);

        // Reserve then release r3.
        step(0, 0, '0, 1, 3, 3, 0, 3, 0);
        rd3(3, 3, 3);
        step(1, 3, 64'd42, 0, 0, 3, 3, 3, 0);
        rd3(3, 3, 3);

        // Reserve and write r9 together: new producer wins.
        step(1, 9, 64'h77, 1, 9, 9, 9, 9, 0);
        rd3(9, 9, 3);
        step(0, 0, '0, 1, 9, 9, 9, 9, 0);         // re-reserve a busy register
        rd3(9, 0, 0);

        // Fill r1..r15 reading three distinct addresses each cycle.
        for (int i = 1; i < DP; i++)
            step(1, i, DW'(i) * 64'h0101, 0, 0, i, (i % 15) + 1, ((i + 7) % 15) + 1, 0);
        for (int i = 1; i < DP; i += 3) rd3(i, i+1, i+2);
        for (int i = 1; i < DP; i++) step(0, 0, '0, 1, i, i, 0, DP-i, 0);
        rd3(1, 8, 15);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic [DW-1:0] d;
            d = {$urandom(), $urandom()};
            step($urandom_range(0, 99) < 50, $urandom_range(0, DP-1), d,
                 $urandom_range(0, 99) < 30, $urandom_range(0, DP-1),
                 $urandom_range(0, DP-1), $urandom_range(0, DP-1),
                 $urandom_range(0, DP-1), $urandom_range(0, 99) < 1);
        end
        rd3(1, 2, 3);

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
